// File: rtl/moving_average_scheduler_if.sv
// Handshake bundle for moving_average_scheduler: per-channel sample inputs
// with a shared ready vector, and the single tagged result output.
interface moving_average_scheduler_if #(
    parameter int NCH = 4,
    parameter int DW  = 8
);
    logic [NCH-1:0]    in_valid;
    logic [NCH*DW-1:0] in_data;
    logic [NCH-1:0]    in_ready;
    logic              out_valid;
    logic [2:0]        out_chan;
    logic [DW-1:0]     out_data;
    logic              out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_chan, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_chan, out_data
    );
endinterface

// File: rtl/moving_average_scheduler.sv
// moving_average_scheduler: one shared W-tap moving-average datapath,
// time-multiplexed over NCH sample streams by a round-robin arbiter.
// Each channel keeps its own history and running sum. Every admitted sample
// produces one result, tagged with its channel, on the following cycle.
// Optional build macro MAVG_SCHED_FLUSH_EN adds a synchronous flush input
// that clears all histories, sums and the rr pointer but leaves a pending
// result in place.
module moving_average_scheduler #(
    parameter int NCH   = 4,
    parameter int DW    = 8,
    parameter int LOG2W = 2
) (
    input  logic system1000,
    input  logic system1000_rstn,
`ifdef MAVG_SCHED_FLUSH_EN
    input  logic flush,
`endif
    moving_average_scheduler_if.slave bus
);
    localparam int W  = 1 << LOG2W;
    localparam int SW = DW + LOG2W;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic flush_i;
`ifdef MAVG_SCHED_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    logic signed [DW-1:0] hist [NCH][W];
    logic signed [SW-1:0] sum  [NCH];
    logic [CW-1:0]        rr_ptr;

    logic                 out_valid_q;
    logic [2:0]           out_chan_q;
    logic signed [DW-1:0] out_data_q;

    logic                 slot_free;
    logic                 grant_any;
    logic [CW-1:0]        grant_idx;
    logic [NCH-1:0]       grant_oh;
    logic signed [DW-1:0] sample;
    logic signed [DW-1:0] oldest;
    logic signed [SW-1:0] sample_ext;
    logic signed [SW-1:0] oldest_ext;
    logic signed [SW-1:0] new_sum;
    logic signed [SW-1:0] avg_full;

    // Round-robin grant: first requesting channel at or above rr_ptr, wrapping.
    always_comb begin
        logic [CW-1:0] cand;
        cand      = '0;
        slot_free = !out_valid_q || bus.out_ready;
        grant_any = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        for (int off = 0; off < NCH; off++) begin
            cand = CW'((int'(rr_ptr) + off) % NCH);
            if (!grant_any && slot_free && !flush_i && bus.in_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        if (grant_any) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    // Shared datapath: swap the oldest tap of the granted channel for the new sample.
    always_comb begin
        sample = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant_oh[i]) begin
                sample = bus.in_data[i*DW +: DW];
            end
        end
        oldest     = hist[grant_idx][W-1];
        sample_ext = {{LOG2W{sample[DW-1]}}, sample};
        oldest_ext = {{LOG2W{oldest[DW-1]}}, oldest};
        new_sum    = sum[grant_idx] - oldest_ext + sample_ext;
        // Arithmetic shift floors toward negative infinity; the quotient always fits DW bits.
        avg_full   = new_sum >>> LOG2W;
    end

    // Per-channel history, running sums and the rr pointer.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            for (int c = 0; c < NCH; c++) begin
                sum[c] <= '0;
                for (int t = 0; t < W; t++) begin
                    hist[c][t] <= '0;
                end
            end
            rr_ptr <= '0;
        end else if (flush_i) begin
            for (int c = 0; c < NCH; c++) begin
                sum[c] <= '0;
                for (int t = 0; t < W; t++) begin
                    hist[c][t] <= '0;
                end
            end
            rr_ptr <= '0;
        end else if (grant_any) begin
            for (int t = W - 1; t > 0; t--) begin
                hist[grant_idx][t] <= hist[grant_idx][t-1];
            end
            hist[grant_idx][0] <= sample;
            sum[grant_idx]     <= new_sum;
            rr_ptr             <= (grant_idx == CW'(NCH - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Result register: load on accept, drop valid once consumed, hold under backpressure.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            out_data_q  <= '0;
        end else if (grant_any) begin
            out_valid_q <= 1'b1;
            out_chan_q  <= 3'(grant_idx);
            out_data_q  <= avg_full[DW-1:0];
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = grant_oh;
    assign bus.out_valid = out_valid_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_moving_average_scheduler.sv
// Bench for moving_average_scheduler: directed scenarios followed by random
// traffic, all compared against a window-average reference model that
// tracks per-channel sample lists, round-robin order and the output slot.
module tb_moving_average_scheduler;
    localparam int NCH   = 4;
    localparam int DW    = 8;
    localparam int LOG2W = 2;
    localparam int W     = 4;

    logic clk;
    logic rstn;
    logic flush_r;
    int   checks;
    int   failures;

    moving_average_scheduler_if #(.NCH(NCH), .DW(DW)) bus();

    moving_average_scheduler #(.NCH(NCH), .DW(DW), .LOG2W(LOG2W)) dut (
        .system1000      (clk),
        .system1000_rstn (rstn),
`ifdef MAVG_SCHED_FLUSH_EN
        .flush           (flush_r),
`endif
        .bus             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    int   mh [NCH][W];
    int   m_rr;
    logic m_ov;
    int   m_oc;
    int   m_od;

    function automatic int floor_avg(input int s);
        if (s >= 0) return s / W;
        return -((-s + W - 1) / W);
    endfunction

    function automatic logic [31:0] sx(input logic [DW-1:0] v);
        return 32'($signed(v));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic model_clear_hist();
        for (int c = 0; c < NCH; c++)
            for (int t = 0; t < W; t++)
                mh[c][t] = 0;
        m_rr = 0;
    endtask

    task automatic model_reset();
        model_clear_hist();
        m_ov = 1'b0;
        m_oc = 0;
        m_od = 0;
    endtask

    // One clock: drive inputs, check in_ready, clock, update model, check outputs.
    task automatic cycle(input logic [NCH-1:0] v, input logic [NCH*DW-1:0] d, input logic rdy);
        int   g;
        int   s;
        logic [NCH-1:0] exp_rdy;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = rdy;
        #1;
        g = -1;
        if ((!m_ov || rdy) && !flush_r) begin
            for (int o = 0; o < NCH; o++)
                if (g < 0 && v[(m_rr + o) % NCH]) g = (m_rr + o) % NCH;
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        if (g >= 0) begin
            for (int t = W - 1; t > 0; t--) mh[g][t] = mh[g][t-1];
            mh[g][0] = int'($signed(d[g*DW +: DW]));
            s = 0;
            for (int t = 0; t < W; t++) s += mh[g][t];
            m_od = floor_avg(s);
            m_oc = g;
            m_ov = 1'b1;
            m_rr = (g + 1) % NCH;
        end else if (rdy) begin
            m_ov = 1'b0;
        end
        if (flush_r) model_clear_hist();
        chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
        chk("out_chan", 32'(bus.out_chan), 32'(m_oc));
        chk("out_data", sx(bus.out_data), 32'(m_od));
        @(negedge clk);
    endtask

    task automatic send1(input int ch, input int val, input logic rdy);
        logic [NCH-1:0]    v;
        logic [NCH*DW-1:0] d;
        v = '0;
        d = '0;
        v[ch] = 1'b1;
        d[ch*DW +: DW] = DW'(val);
        cycle(v, d, rdy);
    endtask

    task automatic do_reset();
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_chan", 32'(bus.out_chan), 32'd0);
        chk("rst_out_data", sx(bus.out_data), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rstn = 1'b1;
    endtask

    initial begin
        logic [NCH*DW-1:0] d4;
        int exp_a[4];
        int exp_b[4];
        checks   = 0;
        failures = 0;
        flush_r  = 1'b0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        model_reset();
        rstn = 1'b1;
        #1;
        do_reset();

        // ch0 warm-up then window wrap
        exp_a = '{2, 4, 6, 8};
        for (int i = 0; i < 4; i++) begin
            send1(0, 8, 1'b1);
            chk("tp_ch0_warm", sx(bus.out_data), 32'(exp_a[i]));
        end
        exp_b = '{6, 4, 2, 0};
        for (int i = 0; i < 4; i++) begin
            send1(0, 0, 1'b1);
            chk("tp_ch0_wrap", sx(bus.out_data), 32'(exp_b[i]));
        end

        // negative rounding on ch1
        send1(1, -1, 1'b1);
        chk("tp_neg1", sx(bus.out_data), -32'sd1);
        send1(1, -4, 1'b1);
        chk("tp_neg5", sx(bus.out_data), -32'sd2);
        chk("tp_neg_chan", 32'(bus.out_chan), 32'd1);

        // all channels busy from a clean state
        do_reset();
        d4 = {8'd16, 8'd12, 8'd8, 8'd4};
        for (int i = 0; i < 4; i++) begin
            cycle(4'hF, d4, 1'b1);
            chk("tp_rr_chan", 32'(bus.out_chan), 32'(i));
            chk("tp_rr_first", sx(bus.out_data), 32'(i + 1));
        end
        for (int i = 0; i < 5; i++) cycle(4'hF, d4, 1'b1);

        // backpressure for three cycles, then release
        for (int i = 0; i < 3; i++) cycle(4'hF, d4, 1'b0);
        for (int i = 0; i < 5; i++) cycle(4'hF, d4, 1'b1);
        cycle('0, '0, 1'b1);

        // asynchronous reset with a result in flight
        do_reset();
        send1(2, 16, 1'b1);
        send1(2, 16, 1'b1);
        chk("tp_pre_rst", sx(bus.out_data), 32'd8);
        bus.in_valid = '0;
        #2;
        rstn = 1'b0;
        #1;
        chk("tp_async_rst_valid", 32'(bus.out_valid), 32'd0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        send1(2, 16, 1'b1);
        chk("tp_post_rst", sx(bus.out_data), 32'd4);

`ifdef MAVG_SCHED_FLUSH_EN
        send1(2, 16, 1'b1);
        send1(2, 16, 1'b1);
        flush_r = 1'b1;
        send1(2, 16, 1'b0);
        flush_r = 1'b0;
        chk("tp_flush_pending_v", 32'(bus.out_valid), 32'd1);
        chk("tp_flush_pending_d", sx(bus.out_data), 32'd12);
        send1(2, 16, 1'b1);
        chk("tp_post_flush", sx(bus.out_data), 32'd4);
`endif

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [NCH-1:0]    rv;
            logic [NCH*DW-1:0] rd;
            rv = NCH'($urandom_range(0, (1 << NCH) - 1));
            rd = (NCH*DW)'($urandom);
            cycle(rv, rd, $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/moving_average_scheduler.md
Name: moving_average_scheduler

Overview:
- Time-multiplexes one moving-average datapath across NCH sample streams.
- Each channel has a signed DW-bit valid/ready input.
- A round-robin arbiter admits at most one sample per cycle and updates that channel's private history and running sum.
- Emits one tagged averaged result per admitted sample; sits between the ADC/channel fabric and downstream consumers of the system1000 domain.

Parameters:
- NCH, 4, number of input channels (2..8)
- DW, 8, sample and result width, signed two's complement
- LOG2W, 2, log2 of window length W (W = 4); window is a power of two

Ports:
- system1000  input  1  clock, all state on rising edge
- system1000_rstn  input  1  asynchronous reset, active low
- in_valid  input  NCH  per-channel sample valid
- in_data  input  NCH*DW  per-channel signed sample; channel i at bits [i*DW +: DW]
- in_ready  output  NCH  per-channel accept; at most one bit high per cycle
- out_valid  output  1  result valid
- out_chan  output  3  channel index of current result
- out_data  output  DW  signed moving average
- out_ready  input  1  downstream accept

Behaviour:
- Reset (asynchronous on system1000_rstn low, one clock, active-low async fixed):
  - out_valid=0, out_chan=0, out_data=0.
  - All history entries and running sums = 0; rr pointer = 0.
- Output slot free: slot_free = !out_valid || out_ready.
- Arbitration (combinational):
  - Requests are in_valid masked by slot_free.
  - Grant is the first requesting channel searching upward from rr pointer, wrapping NCH-1 -> 0.
  - in_ready = one-hot grant; all zero if no request or slot not free.
  - Combinational out_ready -> in_ready path is permitted.
- Accept: in_valid[k] && in_ready[k] on a clock edge. On accept of channel k:
  - new_sum = sum[k] - hist[k][W-1] + sample; width DW+LOG2W signed, never overflows.
  - hist[k] shifts: hist[k][0] = sample; oldest entry is discarded.
  - sum[k] = new_sum.
  - out_data = new_sum >>> LOG2W (arithmetic shift, rounds toward negative infinity), truncated to DW bits (always fits).
  - out_chan = k; out_valid = 1.
  - rr pointer = (k+1) mod NCH.
- Latency: result valid the cycle after accept; one result per cycle sustained when out_ready is high.
- Backpressure: while out_valid && !out_ready, out_* are held stable and no accept occurs.
- If out_ready is high and no accept occurs, out_valid -> 0 next cycle.
- Non-granted channels' state and the rr pointer are unchanged when there is no accept.
- Warm-up: history starts at zero, so the first W-1 results per channel include zeros; no special case.
- Reset mid-operation: the in-flight result is discarded and all histories are cleared.

Optional Feature:
- Macro: MAVG_SCHED_FLUSH_EN.
- When defined:
  - Extra input port flush (1 bit), synchronous.
  - In a cycle with flush=1: in_ready is all zero, so no accept occurs.
  - On that edge all hist entries and sums clear to 0 and the rr pointer returns to 0.
  - The out register is unaffected; a pending result stays until consumed.
  - Flush takes priority over any simultaneous request.
- When undefined: no flush port, no flush logic; behaviour exactly as above.

Test Plan:
- Ch0 only, samples 8,8,8,8, out_ready=1 -> out_data 2,4,6,8, out_chan=0, each one cycle after accept.
- Window wrap, ch0: 8,8,8,8 then 0 -> 5th result 6; then 0,0,0 -> results 4,2,0.
- Negative rounding, ch1: single sample -1 -> out_data -1; sample -4 next -> sum -5 -> out_data -2.
- All four channels valid continuously with distinct constants 4,8,12,16 -> grants cycle 0,1,2,3,0,...; per-channel first results 1,2,3,4; no cross-channel contamination.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 -> out_* held, in_ready=0; release -> accepts resume, rr pointer continues correctly.
- Reset asserted mid-stream after ch2 has history 16,16 -> out_valid=0 immediately; after release, ch2 sample 16 -> out_data 4.
- With MAVG_SCHED_FLUSH_EN, same stimulus as reset case with flush instead -> next ch2 sample 16 -> 4; pending output retained.
